sid_regs: RTL and testbench

//  CPU-side register file for the SID. Decodes bus writes into per-voice and filter register fields

---
 rtl/sid_pkg.sv | 38 +++
 rtl/sid_bus_decay.sv | 57 +++++
 rtl/sid_regs.sv | 154 +++++++++++++++
 tb/tb_sid_regs.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sid_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sid_pkg: SID register map, voice stride and default bus-decay constants     |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package sid_pkg;

  typedef enum logic {
    SID_6581 = 1'b0,
    SID_8580 = 1'b1
  } sid_model_e;

  // Per-voice offsets, added to voice_index * SID_VOICE_STRIDE
  localparam logic [4:0] SID_FREQ_LO  = 5'h00;
  localparam logic [4:0] SID_FREQ_HI  = 5'h01;
  localparam logic [4:0] SID_PW_LO    = 5'h02;
  localparam logic [4:0] SID_PW_HI    = 5'h03;
  localparam logic [4:0] SID_CONTROL  = 5'h04;
  localparam logic [4:0] SID_ATT_DEC  = 5'h05;
  localparam logic [4:0] SID_SUS_REL  = 5'h06;

  localparam logic [4:0] SID_FC_LO    = 5'h15;
  localparam logic [4:0] SID_FC_HI    = 5'h16;
  localparam logic [4:0] SID_RES_FILT = 5'h17;
  localparam logic [4:0] SID_MODE_VOL = 5'h18;
  localparam logic [4:0] SID_POTX     = 5'h19;
  localparam logic [4:0] SID_POTY     = 5'h1A;
  localparam logic [4:0] SID_OSC3     = 5'h1B;
  localparam logic [4:0] SID_ENV3     = 5'h1C;

  localparam int SID_VOICE_STRIDE = 7;

  localparam int DECAY_6581_DEF = 7424;
  localparam int DECAY_8580_DEF = 663552;
  localparam int DCNT_W_DEF     = 20;

endpackage
`default_nettype wire

// File: rtl/sid_bus_decay.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sid_bus_decay: last-transferred bus byte with model-dependent decay to zero |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sid_bus_decay
  import sid_pkg::*;
#(
  parameter int DECAY_6581 = DECAY_6581_DEF,
  parameter int DECAY_8580 = DECAY_8580_DEF,
  parameter int DCNT_W     = DCNT_W_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic       mode,
  input  logic       load,
  input  logic [7:0] din,
  output logic [7:0] bus_val
);

  logic [7:0]        bus_q, bus_d;
  logic [DCNT_W-1:0] cnt_q, cnt_d;
  logic [DCNT_W-1:0] reload;

  assign reload = (sid_model_e'(mode) == SID_8580) ? DCNT_W'(DECAY_8580)
                                                   : DCNT_W'(DECAY_6581);

  // An access always wins over expiry: it reloads and never clears.
  always_comb begin
    bus_d = bus_q;
    cnt_d = cnt_q;
    if (ce_1m) begin
      if (load) begin
        bus_d = din;
        cnt_d = reload;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DCNT_W'(1)) bus_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus_q <= 8'h00;
      cnt_q <= '0;
    end else begin
      bus_q <= bus_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus_val = bus_q;

endmodule
`default_nettype wire

// File: rtl/sid_regs.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | sid_regs: SID CPU-side register file - write decode, register bank, readback|
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module sid_regs
  import sid_pkg::*;
#(
  parameter int DECAY_6581 = DECAY_6581_DEF,
  parameter int DECAY_8580 = DECAY_8580_DEF,
  parameter int DCNT_W     = DCNT_W_DEF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce_1m,
  input  logic        mode,
  input  logic        cs,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [15:0] freq0,
  output logic [15:0] freq1,
  output logic [15:0] freq2,
  output logic [11:0] pw0,
  output logic [11:0] pw1,
  output logic [11:0] pw2,
  output logic [7:0]  control0,
  output logic [7:0]  control1,
  output logic [7:0]  control2,
  output logic [7:0]  att_dec0,
  output logic [7:0]  att_dec1,
  output logic [7:0]  att_dec2,
  output logic [7:0]  sus_rel0,
  output logic [7:0]  sus_rel1,
  output logic [7:0]  sus_rel2,
  output logic [10:0] fc,
  output logic [7:0]  res_filt,
  output logic [7:0]  mode_vol,
  input  logic [7:0]  pot_x,
  input  logic [7:0]  pot_y,
  input  logic [7:0]  osc3,
  input  logic [7:0]  env3
);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n_int;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  logic [15:0] freq_q    [3];
  logic [11:0] pw_q      [3];
  logic [7:0]  control_q [3];
  logic [7:0]  att_dec_q [3];
  logic [7:0]  sus_rel_q [3];
  logic [10:0] fc_q;
  logic [7:0]  res_filt_q;
  logic [7:0]  mode_vol_q;
  logic [7:0]  data_out_q;
  logic [7:0]  rd_data;
  logic [7:0]  bus_val;
  logic        wr_en;
  logic        rd_en;

  assign wr_en = ce_1m & cs & we;
  assign rd_en = ce_1m & cs & ~we;

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int) begin
      for (int v = 0; v < 3; v++) begin
        freq_q[v]    <= '0;
        pw_q[v]      <= '0;
        control_q[v] <= '0;
        att_dec_q[v] <= '0;
        sus_rel_q[v] <= '0;
      end
      fc_q       <= '0;
      res_filt_q <= '0;
      mode_vol_q <= '0;
    end else if (wr_en) begin
      for (int v = 0; v < 3; v++) begin
        if (addr == 5'(SID_VOICE_STRIDE * v) + SID_FREQ_LO) freq_q[v][7:0]   <= data_in;
        if (addr == 5'(SID_VOICE_STRIDE * v) + SID_FREQ_HI) freq_q[v][15:8]  <= data_in;
        if (addr == 5'(SID_VOICE_STRIDE * v) + SID_PW_LO)   pw_q[v][7:0]     <= data_in;
        if (addr == 5'(SID_VOICE_STRIDE * v) + SID_PW_HI)   pw_q[v][11:8]    <= data_in[3:0];
        if (addr == 5'(SID_VOICE_STRIDE * v) + SID_CONTROL) control_q[v]     <= data_in;
        if (addr == 5'(SID_VOICE_STRIDE * v) + SID_ATT_DEC) att_dec_q[v]     <= data_in;
        if (addr == 5'(SID_VOICE_STRIDE * v) + SID_SUS_REL) sus_rel_q[v]     <= data_in;
      end
      if (addr == SID_FC_LO)    fc_q[2:0]  <= data_in[2:0];
      if (addr == SID_FC_HI)    fc_q[10:3] <= data_in;
      if (addr == SID_RES_FILT) res_filt_q <= data_in;
      if (addr == SID_MODE_VOL) mode_vol_q <= data_in;
    end
  end

  always_comb begin
    rd_data = bus_val;
    case (addr)
      SID_POTX: rd_data = pot_x;
      SID_POTY: rd_data = pot_y;
      SID_OSC3: rd_data = osc3;
      SID_ENV3: rd_data = env3;
      default:  rd_data = bus_val;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n_int) begin
    if (!rst_n_int)  data_out_q <= 8'h00;
    else if (rd_en)  data_out_q <= rd_data;
  end

  sid_bus_decay #(
    .DECAY_6581 (DECAY_6581),
    .DECAY_8580 (DECAY_8580),
    .DCNT_W     (DCNT_W)
  ) u_bus_decay (
    .clock   (clock),
    .reset_n (rst_n_int),
    .ce_1m   (ce_1m),
    .mode    (mode),
    .load    (cs),
    .din     (we ? data_in : rd_data),
    .bus_val (bus_val)
  );

  assign data_out = data_out_q;
  assign freq0    = freq_q[0];
  assign freq1    = freq_q[1];
  assign freq2    = freq_q[2];
  assign pw0      = pw_q[0];
  assign pw1      = pw_q[1];
  assign pw2      = pw_q[2];
  assign control0 = control_q[0];
  assign control1 = control_q[1];
  assign control2 = control_q[2];
  assign att_dec0 = att_dec_q[0];
  assign att_dec1 = att_dec_q[1];
  assign att_dec2 = att_dec_q[2];
  assign sus_rel0 = sus_rel_q[0];
  assign sus_rel1 = sus_rel_q[1];
  assign sus_rel2 = sus_rel_q[2];
  assign fc       = fc_q;
  assign res_filt = res_filt_q;
  assign mode_vol = mode_vol_q;

endmodule
`default_nettype wire

// File: tb/tb_sid_regs.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_sid_regs: directed self-checking bench for the SID register file         |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_sid_regs;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ce_1m;
  logic        mode;
  logic        cs;
  logic        we;
  logic [4:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [15:0] freq0, freq1, freq2;
  logic [11:0] pw0, pw1, pw2;
  logic [7:0]  control0, control1, control2;
  logic [7:0]  att_dec0, att_dec1, att_dec2;
  logic [7:0]  sus_rel0, sus_rel1, sus_rel2;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;
  logic [7:0]  pot_x, pot_y, osc3, env3;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sid_regs dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .ce_1m    (ce_1m),
    .mode     (mode),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .freq0    (freq0),
    .freq1    (freq1),
    .freq2    (freq2),
    .pw0      (pw0),
    .pw1      (pw1),
    .pw2      (pw2),
    .control0 (control0),
    .control1 (control1),
    .control2 (control2),
    .att_dec0 (att_dec0),
    .att_dec1 (att_dec1),
    .att_dec2 (att_dec2),
    .sus_rel0 (sus_rel0),
    .sus_rel1 (sus_rel1),
    .sus_rel2 (sus_rel2),
    .fc       (fc),
    .res_filt (res_filt),
    .mode_vol (mode_vol),
    .pot_x    (pot_x),
    .pot_y    (pot_y),
    .osc3     (osc3),
    .env3     (env3)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Each access occupies one clock edge; callers are always 1 time unit past an edge.
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; data_in = d;
    @(posedge clock); #1;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a);
    cs = 1'b1; we = 1'b0; addr = a;
    @(posedge clock); #1;
    cs = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; ce_1m = 1'b1; mode = 1'b0; cs = 1'b0; we = 1'b0;
    addr = '0; data_in = '0; pot_x = '0; pot_y = '0; osc3 = '0; env3 = '0;
    idle(3);
    reset_n = 1'b1;
    idle(4);

    check("reset_data_out", 16'(data_out), 16'h00);
    check("reset_freq0", freq0, 16'h0000);
    check("reset_fc", 16'(fc), 16'h000);

    // Voice mapping
    wr(5'h07, 8'h34);
    wr(5'h08, 8'h12);
    wr(5'h0A, 8'hFF);
    check("freq1", freq1, 16'h1234);
    check("pw1", 16'(pw1), 16'hF00);
    check("freq0_unchanged", freq0, 16'h0000);
    check("freq2_unchanged", freq2, 16'h0000);
    check("pw0_unchanged", 16'(pw0), 16'h000);
    wr(5'h12, 8'h41);
    wr(5'h05, 8'hA9);
    wr(5'h14, 8'h5C);
    check("control2", 16'(control2), 16'h41);
    check("att_dec0", 16'(att_dec0), 16'hA9);
    check("sus_rel2", 16'(sus_rel2), 16'h5C);
    check("control1_unchanged", 16'(control1), 16'h00);

    // Writes without ce_1m must be ignored
    ce_1m = 1'b0;
    wr(5'h07, 8'h99);
    ce_1m = 1'b1;
    check("ce_gating_freq1", freq1, 16'h1234);

    // Filter
    wr(5'h15, 8'hFF);
    wr(5'h16, 8'hA5);
    check("fc_52F", 16'(fc), 16'h52F);
    wr(5'h15, 8'h00);
    check("fc_528", 16'(fc), 16'h528);
    wr(5'h17, 8'hF3);
    wr(5'h18, 8'h1F);
    check("res_filt", 16'(res_filt), 16'hF3);
    check("mode_vol", 16'(mode_vol), 16'h1F);

    // Readback
    osc3 = 8'h5A; env3 = 8'hC3; pot_x = 8'h11; pot_y = 8'h22;
    rd(5'h1B);
    check("read_osc3", 16'(data_out), 16'h5A);
    rd(5'h1C);
    check("read_env3", 16'(data_out), 16'hC3);
    rd(5'h19);
    check("read_potx", 16'(data_out), 16'h11);
    rd(5'h1A);
    check("read_poty", 16'(data_out), 16'h22);
    idle(2);
    check("data_out_hold", 16'(data_out), 16'h22);
    rd(5'h00);
    check("read_bus_after_read", 16'(data_out), 16'h22);
    wr(5'h1D, 8'h77);
    rd(5'h09);
    check("read_bus_after_wr_1D", 16'(data_out), 16'h77);
    check("freq1_after_wr_1D", freq1, 16'h1234);

    // Decay, 6581
    wr(5'h04, 8'h7E);
    check("control0", 16'(control0), 16'h7E);
    idle(7423);
    rd(5'h04);
    check("decay6581_held", 16'(data_out), 16'h7E);
    wr(5'h04, 8'h3C);
    idle(7424);
    rd(5'h04);
    check("decay6581_cleared", 16'(data_out), 16'h00);

    // Collision on the expiring cycle, then mode change mid-count
    mode = 1'b0;
    wr(5'h00, 8'hAA);
    idle(7423);
    wr(5'h01, 8'h55);
    idle(7423);
    rd(5'h02);
    check("collision_no_clear", 16'(data_out), 16'h55);
    mode = 1'b1;
    idle(7424);
    rd(5'h02);
    check("mode_change_mid_count", 16'(data_out), 16'h00);
    wr(5'h1F, 8'hC7);
    idle(10000);
    rd(5'h03);
    check("decay8580_held", 16'(data_out), 16'hC7);

    // Reset mid-run acts without a clock edge
    wr(5'h06, 8'hE4);
    check("sus_rel0", 16'(sus_rel0), 16'hE4);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_sus_rel0", 16'(sus_rel0), 16'h00);
    check("async_rst_freq1", freq1, 16'h0000);
    check("async_rst_data_out", 16'(data_out), 16'h00);
    check("async_rst_fc", 16'(fc), 16'h000);
    idle(2);
    reset_n = 1'b1;
    idle(4);
    rd(5'h00);
    check("read_after_reset", 16'(data_out), 16'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
